// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers pixel position and data-enable from HS/VS,
// checks line/frame timing against nominal values and reports lock/errors.
module vga_sync_receiver #(
    parameter int H_ACTIVE    = 640,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pix_stb,
    input  logic       i_hs,
    input  logic       i_vs,
    output logic [9:0] o_x,
    output logic [8:0] o_y,
    output logic       o_de,
    output logic       o_locked,
    output logic       o_frame_start,
    output logic       o_err
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [9:0] CNT_MAX = 10'd1023;
    localparam logic [9:0] CNT_PRE = 10'd1022;
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_SW    = 10'(H_SYNC);
    localparam logic [9:0] H_X0    = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_X1    = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_SW    = 10'(V_SYNC);
    localparam logic [9:0] V_Y0    = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_Y1    = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [2:0] LOCK_N  = 3'(LOCK_FRAMES);

    state_t     state, state_n;
    logic [2:0] good, good_n;
    logic [9:0] h_cnt, h_cnt_n;
    logic [9:0] v_cnt, v_cnt_n;
    logic [9:0] hs_w, hs_w_n;
    logic [9:0] vs_w, vs_w_n;
    logic       hs_d, vs_d;
    logic       h_first, h_first_n;
    logic       v_first, v_first_n;
    logic       hs_start, hs_rise, vs_start, vs_end;
    logic       err, enter_hunt;
    logic       de_n, fs_n, err_out_n;
    logic [9:0] x_n;
    logic [8:0] y_n;

    // Edge detection, position counters and timing violation detection
    always_comb begin
        hs_start = i_pix_stb & ~i_hs & hs_d;
        hs_rise  = i_pix_stb & i_hs & ~hs_d;
        vs_start = hs_start & ~i_vs & vs_d;
        vs_end   = hs_start & i_vs & ~vs_d;
        h_cnt_n  = h_cnt;
        hs_w_n   = hs_w;
        v_cnt_n  = v_cnt;
        vs_w_n   = vs_w;
        err      = 1'b0;
        if (hs_start) begin
            h_cnt_n = '0;
            hs_w_n  = 10'd1;
            if (!h_first && h_cnt != H_LAST)
                err = 1'b1;
        end else if (i_pix_stb) begin
            if (h_cnt != CNT_MAX)
                h_cnt_n = h_cnt + 10'd1;
            if (h_cnt == CNT_PRE)
                err = 1'b1;
            if (!i_hs && hs_w != CNT_MAX)
                hs_w_n = hs_w + 10'd1;
        end
        if (hs_rise && hs_w != H_SW)
            err = 1'b1;
        if (vs_start) begin
            v_cnt_n = '0;
            vs_w_n  = 10'd1;
            if (!v_first && v_cnt != V_LAST)
                err = 1'b1;
        end else if (hs_start) begin
            if (v_cnt != CNT_MAX)
                v_cnt_n = v_cnt + 10'd1;
            if (!i_vs && vs_w != CNT_MAX)
                vs_w_n = vs_w + 10'd1;
        end
        if (vs_end && vs_w != V_SW)
            err = 1'b1;
    end

    // Lock state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= HUNT;
            good  <= '0;
        end else begin
            state <= state_n;
            good  <= good_n;
        end
    end

    // Lock next-state: count clean frames, fall back to HUNT on any error
    always_comb begin
        state_n = state;
        good_n  = good;
        if (i_pix_stb) begin
            unique case (state)
                HUNT: begin
                    if (vs_start) begin
                        state_n = SYNC;
                        good_n  = '0;
                    end
                end
                SYNC: begin
                    if (err) begin
                        state_n = HUNT;
                    end else if (vs_start) begin
                        good_n = good + 3'd1;
                        if (good + 3'd1 == LOCK_N)
                            state_n = LOCKED;
                    end
                end
                LOCKED: begin
                    if (err)
                        state_n = HUNT;
                end
                default: state_n = HUNT;
            endcase
        end
    end

    // Output decode from the post-edge counters and state
    always_comb begin
        enter_hunt = (state != HUNT) && (state_n == HUNT);
        h_first_n  = enter_hunt ? 1'b1 : (hs_start ? 1'b0 : h_first);
        v_first_n  = enter_hunt ? 1'b1 : (vs_start ? 1'b0 : v_first);
        de_n = (state_n == LOCKED)
            && (h_cnt_n >= H_X0) && (h_cnt_n <= H_X1)
            && (v_cnt_n >= V_Y0) && (v_cnt_n <= V_Y1);
        x_n  = de_n ? (h_cnt_n - H_X0) : '0;
        y_n  = de_n ? 9'(v_cnt_n - V_Y0) : '0;
        fs_n = de_n && (h_cnt_n == H_X0) && (v_cnt_n == V_Y0);
        err_out_n = err && (state != HUNT);
    end

    // Counter, sync history and first-check flag registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            hs_w    <= '0;
            vs_w    <= '0;
            hs_d    <= 1'b1;
            vs_d    <= 1'b1;
            h_first <= 1'b1;
            v_first <= 1'b1;
        end else begin
            h_cnt   <= h_cnt_n;
            v_cnt   <= v_cnt_n;
            hs_w    <= hs_w_n;
            vs_w    <= vs_w_n;
            h_first <= h_first_n;
            v_first <= v_first_n;
            if (i_pix_stb)
                hs_d <= i_hs;
            if (hs_start)
                vs_d <= i_vs;
        end
    end

    // Registered outputs; pulses clear on the cycle after they fire
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_x           <= '0;
            o_y           <= '0;
            o_de          <= 1'b0;
            o_locked      <= 1'b0;
            o_frame_start <= 1'b0;
            o_err         <= 1'b0;
        end else if (i_pix_stb) begin
            o_x           <= x_n;
            o_y           <= y_n;
            o_de          <= de_n;
            o_locked      <= (state_n == LOCKED);
            o_frame_start <= fs_n;
            o_err         <= err_out_n;
        end else begin
            o_frame_start <= 1'b0;
            o_err         <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Randomized bench for vga_sync_receiver on a shrunken timing (20x12),
// compared strobe by strobe against a behavioural reference model.
module tb_vga_sync_receiver;

    localparam int HA  = 10;
    localparam int HSW = 4;
    localparam int HBP = 3;
    localparam int HT  = 20;
    localparam int VA  = 4;
    localparam int VSW = 2;
    localparam int VBP = 3;
    localparam int VT  = 12;
    localparam int LF  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stb = 1'b0;
    logic       hs = 1'b1;
    logic       vs = 1'b1;
    logic [9:0] o_x;
    logic [8:0] o_y;
    logic       o_de, o_locked, o_fs, o_err;

    vga_sync_receiver #(
        .H_ACTIVE(HA), .H_SYNC(HSW), .H_BP(HBP), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VSW), .V_BP(VBP), .V_TOTAL(VT),
        .LOCK_FRAMES(LF)
    ) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .i_pix_stb(stb),
        .i_hs(hs),
        .i_vs(vs),
        .o_x(o_x),
        .o_y(o_y),
        .o_de(o_de),
        .o_locked(o_locked),
        .o_frame_start(o_fs),
        .o_err(o_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // reference model: positions as plain integers, mode 0=hunt 1=sync 2=lock
    int m_pos, m_hsw, m_line, m_vsw, m_mode, m_good;
    bit m_hsd, m_vsat, m_hfirst, m_vfirst;
    logic [9:0] e_x;
    logic [8:0] e_y;
    logic e_de, e_lk, e_fs, e_err;

    function automatic int sat(int a);
        return (a > 1023) ? 1023 : a;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_hsw = 0; m_line = 0; m_vsw = 0;
        m_mode = 0; m_good = 0;
        m_hsd = 1; m_vsat = 1; m_hfirst = 1; m_vfirst = 1;
        e_x = '0; e_y = '0;
        e_de = 0; e_lk = 0; e_fs = 0; e_err = 0;
    endtask

    task automatic model_step(bit h, bit v);
        bit hst, hrise, vst, vend, bad, was_hunt, act;
        hst = !h && m_hsd;
        hrise = h && !m_hsd;
        vst = 0; vend = 0; bad = 0;
        if (hst) begin
            if (!m_hfirst && m_pos + 1 != HT) bad = 1;
            m_hfirst = 0;
            m_pos = 0;
            m_hsw = 1;
            vst = !v && m_vsat;
            vend = v && !m_vsat;
            if (vst) begin
                if (!m_vfirst && m_line + 1 != VT) bad = 1;
                m_vfirst = 0;
                m_line = 0;
                m_vsw = 1;
            end else begin
                if (vend && m_vsw != VSW) bad = 1;
                m_line = sat(m_line + 1);
                if (!v) m_vsw = sat(m_vsw + 1);
            end
            m_vsat = v;
        end else begin
            if (m_pos == 1022) bad = 1;
            m_pos = sat(m_pos + 1);
            if (!h) m_hsw = sat(m_hsw + 1);
            if (hrise && m_hsw != HSW) bad = 1;
        end
        m_hsd = h;
        e_err = bad && (m_mode != 0);
        was_hunt = (m_mode == 0);
        if (m_mode == 0) begin
            if (vst) begin m_mode = 1; m_good = 0; end
        end else if (bad) begin
            m_mode = 0;
        end else if (m_mode == 1 && vst) begin
            m_good++;
            if (m_good == LF) m_mode = 2;
        end
        if (!was_hunt && m_mode == 0) begin
            m_hfirst = 1;
            m_vfirst = 1;
        end
        act = (m_mode == 2)
            && m_pos >= HSW + HBP && m_pos < HSW + HBP + HA
            && m_line >= VSW + VBP && m_line < VSW + VBP + VA;
        e_de = act;
        e_lk = (m_mode == 2);
        e_x = act ? 10'(m_pos - (HSW + HBP)) : 10'd0;
        e_y = act ? 9'(m_line - (VSW + VBP)) : 9'd0;
        e_fs = act && m_pos == HSW + HBP && m_line == VSW + VBP;
    endtask

    int  gen_vs = 0;
    int  lock_at = -1;
    int  de_cnt = 0;
    int  fs_cnt = 0;
    int  err_cnt = 0;
    int  last_x = 0;
    int  last_y = 0;
    bit  prev_lk = 0;

    task automatic cyc(bit s, bit h, bit v);
        @(negedge clk);
        stb = s; hs = h; vs = v;
        @(posedge clk);
        #1;
        if (s) model_step(h, v);
        else begin e_fs = 0; e_err = 0; end
        check("outs", 32'({o_x, o_y, o_de, o_locked, o_fs, o_err}),
              32'({e_x, e_y, e_de, e_lk, e_fs, e_err}));
        if (o_err) err_cnt++;
        if (o_fs) fs_cnt++;
        if (s && o_de) begin
            de_cnt++;
            last_x = int'(o_x);
            last_y = int'(o_y);
        end
        if (o_locked && !prev_lk) lock_at = gen_vs;
        prev_lk = o_locked;
    endtask

    task automatic pix(bit h, bit v);
        repeat ($urandom_range(1, 3)) cyc(1'b0, hs, vs);
        cyc(1'b1, h, v);
    endtask

    task automatic run_lines(int first, int last, int bad_line = -1,
                             int bad_len = HT, int bad_hw = HSW,
                             int vsl = VSW);
        for (int l = first; l <= last; l++) begin
            int len, hw;
            if (l == 0) gen_vs++;
            len = (l == bad_line) ? bad_len : HT;
            hw  = (l == bad_line) ? bad_hw : HSW;
            for (int i = 0; i < len; i++) pix(i >= hw, l >= vsl);
        end
    endtask

    task automatic frame();
        run_lines(0, VT - 1);
    endtask

    task automatic expect_relock(string tag);
        int base;
        base = gen_vs;
        lock_at = -1;
        repeat (3) frame();
        check(tag, 32'(lock_at - base), 32'd3);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_out"}, 32'({o_x, o_y, o_de, o_locked, o_fs, o_err}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        model_reset();
        #23;
        check_zero("reset");
        check("reset_lk", 32'(o_locked), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // start mid-frame, lock from scratch
        err_cnt = 0;
        repeat (7) pix(1'b1, 1'b1);
        run_lines(7, VT - 1);
        check("hunt_noerr", 32'(err_cnt), 32'd0);
        expect_relock("lock_vs");
        de_cnt = 0; fs_cnt = 0;
        frame();
        check("de_cnt", 32'(de_cnt), 32'(HA * VA));
        check("fs_cnt", 32'(fs_cnt), 32'd1);
        check("last_x", 32'(last_x), 32'(HA - 1));
        check("last_y", 32'(last_y), 32'(VA - 1));

        // one short line while locked
        err_cnt = 0;
        run_lines(0, VT - 1, 6, HT - 1);
        check("len_err", 32'(err_cnt), 32'd1);
        check("len_unlock", 32'(o_locked), 32'd0);
        expect_relock("len_relock");

        // HS low one pixel short while locked
        err_cnt = 0;
        run_lines(0, VT - 1, 5, HT, HSW - 1);
        check("hsw_err", 32'(err_cnt), 32'd1);
        check("hsw_unlock", 32'(o_locked), 32'd0);

        // HS stuck high in SYNC
        frame();
        err_cnt = 0;
        run_lines(0, VT - 1, 4, HSW + 1100, HSW);
        check("to_err", 32'(err_cnt), 32'd1);
        expect_relock("to_relock");

        // random timing faults
        for (int f = 0; f < 8; f++) begin
            int sel, bl, d;
            sel = $urandom_range(0, 6);
            bl = $urandom_range(0, VT - 1);
            d = ($urandom_range(0, 1) == 1) ? 1 : -1;
            unique case (sel)
                3: run_lines(0, VT - 1, bl, HT + d);
                4: run_lines(0, VT - 1, bl, HT, HSW + d);
                5: run_lines(0, VT - 1, -1, HT, HSW, VSW + d);
                6: run_lines(0, VT - 1 + d);
                default: frame();
            endcase
        end

        // async reset mid-frame while locked
        expect_relock("pre_rst_lock");
        run_lines(0, 5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        prev_lk = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        err_cnt = 0;
        run_lines(7, VT - 1);
        check("rst_noerr", 32'(err_cnt), 32'd0);
        expect_relock("rst_relock");

        // strobe gap mid-line in the active area
        err_cnt = 0;
        run_lines(0, 5);
        for (int i = 0; i < 9; i++) pix(i >= HSW, 1'b1);
        repeat (50) cyc(1'b0, 1'b1, 1'b1);
        check("gate_x", 32'(o_x), 32'd1);
        check("gate_y", 32'(o_y), 32'd1);
        check("gate_de", 32'(o_de), 32'd1);
        for (int i = 9; i < HT; i++) pix(1'b1, 1'b1);
        run_lines(7, VT - 1);
        frame();
        check("gate_noerr", 32'(err_cnt), 32'd0);
        check("gate_lock", 32'(o_locked), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
